// File: rtl/gray_2_bin_sync.sv
`default_nettype none
// ============================================================================
//  Module   : gray_2_bin_sync
//  Purpose  : Synchronizes a Gray-coded count from a foreign clock domain,
//             decodes it to binary, reports the step size (delta) and flags
//             samples that changed in more than one bit.
//  Revision : 1.0  initial release
// ============================================================================
module gray_2_bin_sync #(
    parameter int SIZE        = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic            Clk,
    input  logic            Rst_N,
    input  logic [SIZE-1:0] In_Gray,
    input  logic            Err_Clr,
    output logic [SIZE-1:0] Out_Bin,
    output logic            Out_Valid,
    output logic [SIZE-1:0] Out_Delta,
    output logic            Err_Multi_Bit
);

    // Synchronizer chain; stage 0 samples the asynchronous input directly.
    logic [SIZE-1:0] r_sync [SYNC_STAGES];

    logic [SIZE-1:0] r_gray_prev;
    logic            r_primed;
    logic [SIZE-1:0] r_out_bin;
    logic            r_out_valid;
    logic [SIZE-1:0] r_out_delta;
    logic            r_err;

    logic [SIZE-1:0] w_sync_last;
    logic [SIZE-1:0] w_bin_new;
    logic [SIZE-1:0] w_diff;
    logic            w_changed;
    logic            w_multi_bit;

    assign w_sync_last = r_sync[SYNC_STAGES-1];

    generate
        for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_sync
            if (g == 0) begin : g_first
                // First stage captures the raw asynchronous Gray input.
                always_ff @(posedge Clk or negedge Rst_N) begin
                    if (!Rst_N) r_sync[0] <= '0;
                    else        r_sync[0] <= In_Gray;
                end
            end else begin : g_next
                // Plain flop-to-flop stage, no logic between stages.
                always_ff @(posedge Clk or negedge Rst_N) begin
                    if (!Rst_N) r_sync[g] <= '0;
                    else        r_sync[g] <= r_sync[g-1];
                end
            end
        end
    endgenerate

    // MSB-first Gray-to-binary decode of the synchronized sample.
    always_comb begin
        w_bin_new           = '0;
        w_bin_new[SIZE-1]   = w_sync_last[SIZE-1];
        for (int k = SIZE - 2; k >= 0; k--) begin
            w_bin_new[k] = w_bin_new[k+1] ^ w_sync_last[k];
        end
    end

    // More than one differing bit <=> clearing the lowest set bit leaves some bit set.
    assign w_diff      = w_sync_last ^ r_gray_prev;
    assign w_changed   = (w_diff != '0);
    assign w_multi_bit = ((w_diff & (w_diff - SIZE'(1))) != '0);

    // Output stage: prime once after reset, then load on every sample change.
    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            r_gray_prev <= '0;
            r_primed    <= 1'b0;
            r_out_bin   <= '0;
            r_out_valid <= 1'b0;
            r_out_delta <= '0;
            r_err       <= 1'b0;
        end else begin
            r_gray_prev <= w_sync_last;
            r_primed    <= 1'b1;
            if (!r_primed) begin
                r_out_bin   <= w_bin_new;
                r_out_valid <= 1'b1;
                r_out_delta <= '0;
                if (Err_Clr) r_err <= 1'b0;
            end else begin
                if (w_changed) begin
                    r_out_bin   <= w_bin_new;
                    r_out_valid <= 1'b1;
                    r_out_delta <= w_bin_new - r_out_bin;
                end else begin
                    r_out_valid <= 1'b0;
                end
                // A new error takes priority over a clear on the same edge.
                if (w_multi_bit)  r_err <= 1'b1;
                else if (Err_Clr) r_err <= 1'b0;
            end
        end
    end

    assign Out_Bin       = r_out_bin;
    assign Out_Valid     = r_out_valid;
    assign Out_Delta     = r_out_delta;
    assign Err_Multi_Bit = r_err;

endmodule
`default_nettype wire
